// File: rtl/interp_pk_pkg.sv
// interp_pk_pkg: shared mode encoding, width helpers and saturating magnitude for interp_pk_proc
package interp_pk_pkg;

    localparam logic MODE_BYP    = 1'b0;
    localparam logic MODE_INTERP = 1'b1;

    // Window beat counter width; it wraps naturally at 2^win_log2.
    function automatic int win_cnt_w(input int win_log2);
        return win_log2;
    endfunction

    // Sum of grp magnitudes of dw-1 bits each can never overflow this width.
    function automatic int grp_sum_w(input int dw, input int grp);
        return dw - 1 + $clog2(grp);
    endfunction

    // |x| for a dw-bit two's complement value; the most negative code saturates to 2^(dw-1)-1.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int dw);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (dw - 1));
        return (x == lo) ? 32'(-(lo + 32'sd1)) : (x < 0) ? 32'(-x) : 32'(x);
    endfunction

endpackage

// File: rtl/interp_pk_if.sv
// interp_pk_if: sample stream, thresholds and detection flags of interp_pk_proc
// master drives din/din_valid/interp_en/thresholds; slave drives dout/dout_valid/flags
interface interp_pk_if
    import interp_pk_pkg::*;
#(
    parameter int NCH = 8,
    parameter int DW  = 16,
    parameter int GRP = 4
);
    localparam int NG = NCH / GRP;
    localparam int SW = grp_sum_w(DW, GRP);

    logic              interp_en;
    logic [NCH*DW-1:0] din;
    logic              din_valid;
    logic [NCH*DW-1:0] dout;
    logic              dout_valid;
    logic [DW-2:0]     pk_thresh;
    logic [SW-1:0]     sum_thresh;
    logic [NCH-1:0]    pk;
    logic [NG-1:0]     grp_pk;
    logic [NG-1:0]     grp_sum;
    logic              win_done;
    logic              overrun;

    modport master (
        output interp_en, din, din_valid, pk_thresh, sum_thresh,
        input  dout, dout_valid, pk, grp_pk, grp_sum, win_done, overrun
    );

    modport slave (
        input  interp_en, din, din_valid, pk_thresh, sum_thresh,
        output dout, dout_valid, pk, grp_pk, grp_sum, win_done, overrun
    );

endinterface

// File: rtl/interp_pk_proc_pk_chan.sv
// pk_chan: per-channel saturating magnitude, windowed running max and threshold flag
// sample/valid: output beat; last: final beat of window; thresh: peak threshold
// peak: window max including the current beat; pk: registered flag updated after last
module pk_chan
    import interp_pk_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample,
    input  logic          valid,
    input  logic          last,
    input  logic [DW-2:0] thresh,
    output logic [DW-2:0] peak,
    output logic          pk
);
    logic [DW-2:0] mag, run;

    assign mag  = (DW-1)'(abs_sat(32'($signed(sample)), DW));
    assign peak = (valid && mag > run) ? mag : run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= '0;
            pk  <= 1'b0;
        end else begin
            if (valid) run <= last ? '0 : peak;
            if (last) pk <= peak >= thresh;
        end
    end

endmodule

// File: rtl/interp_pk_proc.sv
// interp_pk_proc: 2x linear-midpoint interpolation or pass-through plus windowed peak detection
// clk: processing clock; rst: async active-low reset; bus: slave side of interp_pk_if
module interp_pk_proc
    import interp_pk_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int DW       = 16,
    parameter int GRP      = 4,
    parameter int WIN_LOG2 = 6
) (
    input logic        clk,
    input logic        rst,
    interp_pk_if.slave bus
);
    localparam int NG = NCH / GRP;
    localparam int CW = win_cnt_w(WIN_LOG2);
    localparam int SW = grp_sum_w(DW, GRP);

    logic              mode, ph1, ph2, busy, accept, last;
    logic              dout_valid, win_done, overrun;
    logic [NCH*DW-1:0] cur, prev, mid, dout;
    logic [CW-1:0]     cnt;
    logic [NCH-1:0]    pk;
    logic [NG-1:0]     grp_sum, grp_hit;
    logic [DW-2:0]     peak [NCH];

    // An interpolated sample occupies two output beats; a strobe on the second is dropped.
    assign busy   = ph1 && mode == MODE_INTERP;
    assign accept = bus.din_valid && !busy;
    assign last   = dout_valid && &cnt;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW:0] sum;
        assign sum = {cur[c*DW+DW-1], cur[c*DW +: DW]} + {prev[c*DW+DW-1], prev[c*DW +: DW]};
        assign mid[c*DW +: DW] = sum[DW:1];
        pk_chan #(.DW(DW)) u_pk (
            .clk    (clk),
            .rst    (rst),
            .sample (dout[c*DW +: DW]),
            .valid  (dout_valid),
            .last   (last),
            .thresh (bus.pk_thresh),
            .peak   (peak[c]),
            .pk     (pk[c])
        );
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [SW-1:0] sum;
        always_comb begin
            sum = '0;
            for (int i = 0; i < GRP; i++) sum = sum + SW'(peak[g*GRP+i]);
        end
        assign grp_hit[g]    = sum >= bus.sum_thresh;
        assign bus.grp_pk[g] = |pk[g*GRP +: GRP];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode       <= MODE_BYP;
            ph1        <= 1'b0;
            ph2        <= 1'b0;
            cur        <= '0;
            prev       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            win_done   <= 1'b0;
            overrun    <= 1'b0;
            cnt        <= '0;
            grp_sum    <= '0;
        end else begin
            if (accept) begin
                cur  <= bus.din;
                mode <= bus.interp_en;
                // A mode change restarts interpolation from a zero predecessor.
                prev <= (bus.interp_en == mode) ? cur : '0;
            end
            overrun    <= overrun | (bus.din_valid & busy);
            ph1        <= accept;
            ph2        <= busy;
            dout_valid <= ph1 | ph2;
            if (ph1) dout <= (mode == MODE_INTERP) ? mid : cur;
            else if (ph2) dout <= cur;
            if (dout_valid) cnt <= cnt + 1'b1;
            win_done <= last;
            if (last) grp_sum <= grp_hit;
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.pk         = pk;
    assign bus.grp_sum    = grp_sum;
    assign bus.win_done   = win_done;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_interp_pk_proc.sv
// tb_interp_pk_proc: directed and random stimulus against a per-cycle expected-output model
module tb_interp_pk_proc;
    localparam int NCH  = 8;
    localparam int DW   = 16;
    localparam int GRP  = 4;
    localparam int NG   = NCH / GRP;
    localparam int WIN  = 64;
    localparam int LIM  = (1 << (DW - 1)) - 1;
    localparam int MAXC = 4200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    interp_pk_if #(.NCH(NCH), .DW(DW), .GRP(GRP)) bus ();

    interp_pk_proc #(.NCH(NCH), .DW(DW), .GRP(GRP), .WIN_LOG2(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    logic [NCH*DW-1:0] e_dout [MAXC];
    bit                e_val  [MAXC];
    logic [DW-1:0]     g_ch0  [MAXC];
    bit                g_val  [MAXC];
    bit                g_wd   [MAXC];

    int             m_cur [NCH];
    int             m_max [NCH];
    int             m_cnt, m_int_acc, m_ovr_at, m_wd_at;
    bit             m_mode;
    logic [NCH-1:0] m_pk;
    logic [NG-1:0]  m_gpk, m_gsum;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAXC; i++) begin
            e_val[i]  = 0;
            e_dout[i] = '0;
            g_ch0[i]  = '0;
            g_val[i]  = 0;
            g_wd[i]   = 0;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            m_cur[ch] = 0;
            m_max[ch] = 0;
        end
        cyc       = 0;
        m_cnt     = 0;
        m_int_acc = -10;
        m_ovr_at  = 1 << 30;
        m_wd_at   = -10;
        m_mode    = 0;
        m_pk      = '0;
        m_gpk     = '0;
        m_gsum    = '0;
    endtask

    task automatic reset_checks();
        check("rst_dout", bus.dout, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_pk", bus.pk, 0);
        check("rst_grp_pk", bus.grp_pk, 0);
        check("rst_grp_sum", bus.grp_sum, 0);
        check("rst_win_done", bus.win_done, 0);
        check("rst_overrun", bus.overrun, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.din_valid = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, predict outputs, compare at the falling edge.
    task automatic cycle(input bit v, input logic [NCH*DW-1:0] d, input bit ie);
        logic signed [DW-1:0] x;
        int s, p, mg, sum;
        @(posedge clk);
        #1;
        bus.din_valid = v;
        bus.din       = d;
        bus.interp_en = ie;
        if (v && m_int_acc == cyc - 1) begin
            if (m_ovr_at > cyc + 1) m_ovr_at = cyc + 1;
        end else if (v) begin
            for (int ch = 0; ch < NCH; ch++) begin
                x = d[ch*DW +: DW];
                s = x;
                if (ie) begin
                    p = m_mode ? m_cur[ch] : 0;
                    e_dout[cyc+2][ch*DW +: DW] = DW'((p + s) >>> 1);
                    e_dout[cyc+3][ch*DW +: DW] = DW'(s);
                end else begin
                    e_dout[cyc+2][ch*DW +: DW] = DW'(s);
                end
                m_cur[ch] = s;
            end
            e_val[cyc+2] = 1;
            if (ie) begin
                e_val[cyc+3] = 1;
                m_int_acc = cyc;
            end
            m_mode = ie;
        end
        @(negedge clk);
        g_ch0[cyc] = bus.dout[DW-1:0];
        g_val[cyc] = bus.dout_valid;
        g_wd[cyc]  = bus.win_done;
        check("dout_valid", bus.dout_valid, e_val[cyc]);
        if (e_val[cyc]) check("dout", bus.dout, e_dout[cyc]);
        check("overrun", bus.overrun, cyc >= m_ovr_at);
        check("win_done", bus.win_done, m_wd_at == cyc);
        check("pk", bus.pk, m_pk);
        check("grp_pk", bus.grp_pk, m_gpk);
        check("grp_sum", bus.grp_sum, m_gsum);
        if (e_val[cyc]) begin
            for (int ch = 0; ch < NCH; ch++) begin
                x = e_dout[cyc][ch*DW +: DW];
                s = x;
                mg = (s < 0) ? -s : s;
                if (mg > LIM) mg = LIM;
                if (mg > m_max[ch]) m_max[ch] = mg;
            end
            m_cnt++;
            if (m_cnt == WIN) begin
                for (int ch = 0; ch < NCH; ch++) m_pk[ch] = m_max[ch] >= int'(bus.pk_thresh);
                for (int g = 0; g < NG; g++) begin
                    sum = 0;
                    for (int i = 0; i < GRP; i++) sum += m_max[g*GRP+i];
                    m_gpk[g]  = |m_pk[g*GRP +: GRP];
                    m_gsum[g] = sum >= int'(bus.sum_thresh);
                end
                for (int ch = 0; ch < NCH; ch++) m_max[ch] = 0;
                m_cnt   = 0;
                m_wd_at = cyc + 1;
            end
        end
        cyc++;
    endtask

    function automatic logic [NCH*DW-1:0] mk0(input int v);
        logic [NCH*DW-1:0] r;
        r = '0;
        r[DW-1:0] = DW'(v);
        return r;
    endfunction

    function automatic logic [NCH*DW-1:0] rnd_data(input int amp);
        logic [NCH*DW-1:0] r;
        for (int ch = 0; ch < NCH; ch++) r[ch*DW +: DW] = DW'(int'($urandom_range(0, 2 * amp)) - amp);
        return r;
    endfunction

    function automatic logic [NCH*DW-1:0] win_data(input bit hit);
        logic [NCH*DW-1:0] r;
        r = rnd_data(2000);
        r[4*DW-1:0] = '0;
        if (hit) begin
            r[0*DW +: DW] = DW'(1000);
            r[1*DW +: DW] = DW'(-999);
            r[2*DW +: DW] = DW'(-1000);
            r[3*DW +: DW] = DW'(500);
        end
        return r;
    endfunction

    initial begin
        int wd_early, amp;
        bit ie;
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.interp_en  = 1'b0;
        bus.pk_thresh  = 15'd1000;
        bus.sum_thresh = 17'd3000;
        model_reset();
        #1;
        rst = 1'b0;
        #3;
        reset_checks();
        @(negedge clk);
        rst = 1'b1;

        // interpolation of 100, 200, 300 on ch0
        for (int c = 0; c < 10; c++) cycle(c % 2 == 0 && c <= 4, mk0(100 * (c / 2 + 1)), 1'b1);
        for (int c = 2; c <= 7; c++) begin
            check("t1_dout", g_ch0[c], 16'(50 * (c - 1)));
            check("t1_valid", g_val[c], 1);
        end

        // pass-through, back-to-back
        do_reset();
        for (int c = 0; c < 8; c++) cycle(c < 4, mk0(c + 1), 1'b0);
        for (int c = 2; c <= 5; c++) check("t2_dout", g_ch0[c], 16'(c - 1));
        check("t2_overrun", bus.overrun, 0);

        // consecutive valids in interpolation mode
        do_reset();
        cycle(1'b1, mk0(1), 1'b1);
        cycle(1'b1, mk0(777), 1'b1);
        for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b1);
        check("t3_mid", g_ch0[2], 16'd0);
        check("t3_s0", g_ch0[3], 16'd1);
        check("t3_gap", g_val[4], 0);
        check("t3_sticky", bus.overrun, 1);

        // floor rounding and magnitude saturation
        do_reset();
        bus.pk_thresh = 15'h7fff;
        cycle(1'b1, mk0(-3), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk0(-2), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk0(-32768), 1'b0);
        for (int c = 5; c < 72; c++) cycle(c < 64, '0, 1'b0);
        check("t4_mid0", g_ch0[2], 16'hfffe);
        check("t4_mid1", g_ch0[4], 16'hfffd);
        check("t4_s1", g_ch0[5], 16'hfffe);
        check("t4_min", g_ch0[6], 16'h8000);
        check("t4_wd", g_wd[66], 1);
        check("t4_pk", bus.pk, 8'h01);

        // window flags against thresholds
        do_reset();
        bus.pk_thresh  = 15'd1000;
        bus.sum_thresh = 17'd3000;
        for (int c = 0; c < 72; c++) cycle(c < 64, win_data(c == 10), 1'b0);
        check("t5_wd_early", g_wd[65], 0);
        check("t5_wd", g_wd[66], 1);
        check("t5_pk", bus.pk[3:0], 4'b0101);
        check("t5_grp_pk", bus.grp_pk[0], 1);
        check("t5_grp_sum", bus.grp_sum[0], 1);
        bus.sum_thresh = 17'd3500;
        for (int c = 72; c < 140; c++) cycle(c < 136, win_data(c == 82), 1'b0);
        check("t6_wd", g_wd[138], 1);
        check("t6_pk", bus.pk[3:0], 4'b0101);
        check("t6_grp_sum", bus.grp_sum[0], 0);

        // reset in the middle of a window
        for (int c = 0; c < 30; c++) cycle(1'b1, win_data(1'b0), 1'b0);
        check("t7_pk_before", bus.pk[0], 1);
        do_reset();
        for (int c = 0; c < 70; c++) cycle(c < 64, win_data(1'b0), 1'b0);
        wd_early = 0;
        for (int c = 0; c < 66; c++) wd_early += int'(g_wd[c]);
        check("t7_wd_early", wd_early, 0);
        check("t7_wd", g_wd[66], 1);

        // random traffic with mode changes and overruns
        for (int r = 0; r < 2; r++) begin
            do_reset();
            bus.pk_thresh  = 15'($urandom_range(1500, 1990));
            bus.sum_thresh = 17'($urandom_range(5000, 7500));
            ie  = 1'b0;
            amp = 1000;
            for (int c = 0; c < 1600; c++) begin
                if (c % 100 == 0) amp = $urandom_range(500, 2500);
                if ($urandom_range(0, 19) == 0) ie = ~ie;
                cycle($urandom_range(0, 99) < 60, rnd_data(amp), ie);
            end
            for (int c = 0; c < 4; c++) cycle(1'b0, '0, ie);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interp_pk_proc.md
Name: interp_pk_proc

Overview:
- Parametrised successor to the fixed 8-channel 2x-interpolate + peak-detect path in the 250 MHz DAC domain.
- Takes NCH signed channels from the ADC-to-250M crossing with a valid strobe and interpolates 2x by linear midpoint, or passes samples through, selectable at run time.
- Measures the per-channel windowed absolute peak, and per-group peak and sum-of-peaks flags against programmable thresholds.
- Sits between the clock-domain crossing and the DAC output mux.

Parameters:
NCH, 8, number of channels (multiple of GRP)
DW, 16, sample width, signed two's complement
GRP, 4, channels per detection group
WIN_LOG2, 6, peak window = 2^WIN_LOG2 output beats

Ports:
clk  in  1  250 MHz processing clock
rst  in  1  reset; asynchronous assert, active-low
interp_en  in  1  1 = 2x linear interpolation, 0 = pass-through
din  in  NCH*DW  channel c at [c*DW +: DW]
din_valid  in  1  input sample strobe
dout  out  NCH*DW  processed samples, same packing
dout_valid  out  1  output beat strobe
pk_thresh  in  DW-1  per-channel peak threshold (unsigned magnitude)
sum_thresh  in  DW+$clog2(GRP)-1  group sum threshold (unsigned)
pk  out  NCH  per-channel peak flag (max >= pk_thresh)
grp_pk  out  NCH/GRP  OR of pk over each group
grp_sum  out  NCH/GRP  sum of group channel maxima >= sum_thresh
win_done  out  1  one-cycle pulse when window results update
overrun  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0, async): dout, dout_valid, pk, grp_pk, grp_sum, win_done, overrun, window counter, running maxima and previous-sample registers all 0. Outputs leave reset state on the first clk edge after deassertion.
- Mode register: interp_en is sampled into the mode register on each accepted din_valid. A change between samples never splits an output pair.
- Pass-through mode: dout = din delayed 2 cycles; dout_valid = din_valid delayed 2 cycles; back-to-back valids allowed.
- Interpolation mode, sample s_n accepted at cycle t:
  - t+2: dout = (s_{n-1} + s_n) >>> 1 (DW+1-bit sum, arithmetic shift, floor rounding).
  - t+3: dout = s_n.
  - dout_valid is high on both cycles.
  - s_{-1} = 0 after reset and after any mode change.
  - Nominal input rate is one valid per 2 cycles, giving a continuous output stream. Longer gaps produce dout_valid low cycles.
  - din_valid at t+1 (consecutive cycles): the sample is dropped, overrun is set (cleared only by reset), and the current pair completes unaffected.
- Magnitude: |dout| per channel, with -2^(DW-1) saturating to 2^(DW-1)-1 (DW-1 bits).
- Window:
  - Counter increments on each dout_valid beat.
  - The beat at count 2^WIN_LOG2-1 is included in the current window and wraps the counter to 0.
  - Cycle after that beat: pk, grp_pk and grp_sum update from the window maxima; win_done pulses; maxima restart from 0. The next window's first beat may coincide with the update cycle.
  - Flags hold between updates.
- Group sum: unsigned sum of GRP channel maxima, width DW-1+$clog2(GRP); no overflow possible.
- Threshold inputs are used combinationally at window end and must be quasi-static.
- Reset mid-window discards partial maxima; the counter restarts at 0.

Decomposition:
- Package interp_pk_pkg holds:
  - abs_sat function (DW-parameterised)
  - window-count width localparam
  - group-sum width localparam
  - mode encoding constants (MODE_BYP = 0, MODE_INTERP = 1)
- One sub-module, pk_chan, instantiated NCH times: abs_sat, running max, window-end capture, and compare against pk_thresh.
- Interpolation datapath and group logic stay in the top level.

Test Plan:
- Interp, ch0 inputs 100, 200, 300 at cycles 0, 2, 4 -> dout ch0 = 50, 100, 150, 200, 250, 300 on cycles 2-7, with dout_valid continuously high.
- Pass-through, valids on 4 consecutive cycles with values 1..4 -> dout 1..4 on cycles 2-5; overrun stays 0.
- Interp, valids at cycles 0 and 1 -> second sample dropped, overrun=1 and sticky; outputs at cycles 2 and 3 are 0>>>1 = 0 and s_0.
- Midpoint rounding: s = -3 then -2 -> midpoint -3 (floor); s = -32768 -> magnitude saturates to 32767; pk set with pk_thresh = 32767.
- WIN_LOG2=6, pk_thresh=1000, sum_thresh=3000, ch0..3 peaks 1000, 999, 1000, 500 in one window:
  - win_done after beat 64.
  - pk[3:0] = 4'b0101, grp_pk[0] = 1.
  - Sum 3499 gives grp_sum[0] = 1; with sum_thresh = 3500, grp_sum[0] = 0.
- Assert rst at beat 30 of a window with pk previously 1 -> all outputs 0 immediately (async); after release, win_done first pulses 64 beats later.
